// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-op and forwarding codes plus the control bundles that
// travel down the ctrl_pipe stage registers.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b001100;

    localparam logic [1:0] ALUOP_ADD  = 2'b11;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Everything the ID stage hands to ID/EX; later stages keep only a subset.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ex_ctl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctl_t;

    // EX/MEM match has priority over MEM/WB: it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_EXMEM;
        else if (wb_hit) return FWD_MEMWB;
        else             return FWD_REG;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: control bundle, source-use flags, illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic       valid,
    input  logic [5:0] opcode,
    output ex_ctl_t    ctl,
    output logic       jump,
    output logic       uses_rs,
    output logic       uses_rt,
    output logic       illegal
);

    always_comb begin
        ctl     = '0;
        jump    = 1'b0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        illegal = 1'b0;
        if (valid) begin
            unique case (opcode)
                OP_RTYPE: begin
                    ctl.reg_dst   = 1'b1;
                    ctl.reg_write = 1'b1;
                    ctl.alu_op    = ALUOP_FUNC;
                    uses_rs       = 1'b1;
                    uses_rt       = 1'b1;
                end
                OP_LW: begin
                    ctl.alu_src    = 1'b1;
                    ctl.mem_read   = 1'b1;
                    ctl.reg_write  = 1'b1;
                    ctl.mem_to_reg = 1'b1;
                    ctl.alu_op     = ALUOP_ADD;
                    uses_rs        = 1'b1;
                end
                OP_SW: begin
                    ctl.alu_src   = 1'b1;
                    ctl.mem_write = 1'b1;
                    ctl.alu_op    = ALUOP_ADD;
                    uses_rs       = 1'b1;
                    uses_rt       = 1'b1;
                end
                OP_BEQ: begin
                    ctl.branch = 1'b1;
                    ctl.alu_op = ALUOP_SUB;
                    uses_rs    = 1'b1;
                    uses_rt    = 1'b1;
                end
                OP_J:    jump    = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control for the 5-stage core: decode, ID/EX..MEM/WB control
// registers, load-use / RAW stall, branch & jump flush, EX forwarding select.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int ALU_OP_W = 2,
    parameter bit EN_FWD   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [5:0]          opcode,
    input  logic [RA_W-1:0]     id_rs,
    input  logic [RA_W-1:0]     id_rt,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                br_zero,
    output logic                stall,
    output logic                flush_ifid,
    output logic                pc_src,
    output logic                jump,
    output logic                ex_reg_dst,
    output logic                ex_alu_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [RA_W-1:0]     wb_wr_addr,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                illegal
);

    ex_ctl_t          dec_ctl, id_ctl;
    logic             dec_jump, dec_uses_rs, dec_uses_rt, dec_illegal;
    logic [RA_W-1:0]  id_dst;

    logic             ex_vld, mem_vld, wb_vld;
    ex_ctl_t          ex_ctl;
    mem_ctl_t         mem_ctl;
    wb_ctl_t          wb_ctl;
    logic [RA_W-1:0]  ex_dst, ex_rs, ex_rt, mem_dst, wb_dst;
    logic             illegal_q;

    ctrl_decode u_dec (
        .valid   (id_valid),
        .opcode  (opcode),
        .ctl     (dec_ctl),
        .jump    (dec_jump),
        .uses_rs (dec_uses_rs),
        .uses_rt (dec_uses_rt),
        .illegal (dec_illegal)
    );

    assign id_dst = dec_ctl.reg_dst ? id_rd : id_rt;

    // A write to r0 is architecturally a no-op; dropping it here keeps r0
    // out of every hazard and forwarding compare downstream.
    always_comb begin
        id_ctl = dec_ctl;
        if (id_dst == '0) id_ctl.reg_write = 1'b0;
    end

    // Stage dst fields are zero unless that stage writes, so a nonzero
    // compare already implies a real register write.
    logic ex_hit, mem_hit, load_use, raw, hazard, id_take;

    assign ex_hit  = ex_dst  != '0 && ((dec_uses_rs && ex_dst  == id_rs) ||
                                       (dec_uses_rt && ex_dst  == id_rt));
    assign mem_hit = mem_dst != '0 && ((dec_uses_rs && mem_dst == id_rs) ||
                                       (dec_uses_rt && mem_dst == id_rt));

    assign load_use = ex_vld && ex_ctl.mem_read && ex_hit;
    assign raw      = (ex_vld && ex_hit) || (mem_vld && mem_hit);
    assign hazard   = id_valid && (EN_FWD ? load_use : raw);

    assign pc_src     = ex_vld && ex_ctl.branch && br_zero;
    assign stall      = hazard && !pc_src;
    assign jump       = id_valid && dec_jump && !stall && !pc_src;
    assign flush_ifid = pc_src || jump;

    // J, illegal opcodes, stalled and squashed instructions all enter EX as bubbles.
    assign id_take = id_valid && !stall && !pc_src && !dec_jump && !dec_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld    <= 1'b0;
            ex_ctl    <= '0;
            ex_dst    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            mem_vld   <= 1'b0;
            mem_ctl   <= '0;
            mem_dst   <= '0;
            wb_vld    <= 1'b0;
            wb_ctl    <= '0;
            wb_dst    <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (id_take) begin
                ex_vld <= 1'b1;
                ex_ctl <= id_ctl;
                ex_dst <= id_ctl.reg_write ? id_dst : '0;
                ex_rs  <= dec_uses_rs ? id_rs : '0;
                ex_rt  <= dec_uses_rt ? id_rt : '0;
            end else begin
                ex_vld <= 1'b0;
                ex_ctl <= '0;
                ex_dst <= '0;
                ex_rs  <= '0;
                ex_rt  <= '0;
            end

            mem_vld            <= ex_vld;
            mem_ctl.mem_read   <= ex_ctl.mem_read;
            mem_ctl.mem_write  <= ex_ctl.mem_write;
            mem_ctl.reg_write  <= ex_ctl.reg_write;
            mem_ctl.mem_to_reg <= ex_ctl.mem_to_reg;
            mem_dst            <= ex_dst;

            wb_vld            <= mem_vld;
            wb_ctl.reg_write  <= mem_ctl.reg_write;
            wb_ctl.mem_to_reg <= mem_ctl.mem_to_reg;
            wb_dst            <= mem_dst;

            if (id_valid && dec_illegal && !pc_src) illegal_q <= 1'b1;
        end
    end

    logic mem_fa, mem_fb, wb_fa, wb_fb;

    assign mem_fa = mem_vld && mem_ctl.reg_write && mem_dst != '0 && mem_dst == ex_rs;
    assign mem_fb = mem_vld && mem_ctl.reg_write && mem_dst != '0 && mem_dst == ex_rt;
    assign wb_fa  = wb_vld  && wb_ctl.reg_write  && wb_dst  != '0 && wb_dst  == ex_rs;
    assign wb_fb  = wb_vld  && wb_ctl.reg_write  && wb_dst  != '0 && wb_dst  == ex_rt;

    assign fwd_a = EN_FWD ? fwd_sel(mem_fa, wb_fa) : FWD_REG;
    assign fwd_b = EN_FWD ? fwd_sel(mem_fb, wb_fb) : FWD_REG;

    assign ex_reg_dst    = ex_ctl.reg_dst;
    assign ex_alu_src    = ex_ctl.alu_src;
    assign ex_alu_op     = ALU_OP_W'(ex_ctl.alu_op);
    assign mem_read      = mem_ctl.mem_read;
    assign mem_write     = mem_ctl.mem_write;
    assign wb_reg_write  = wb_ctl.reg_write;
    assign wb_mem_to_reg = wb_ctl.mem_to_reg;
    assign wb_wr_addr    = wb_dst;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench: DUT "a" has forwarding enabled, DUT "b" has it disabled.
module tb_ctrl_pipe;

    localparam logic [5:0] RT = 6'b000001, LW = 6'b100011, SW = 6'b101011,
                           BQ = 6'b000100, JJ = 6'b001100, BAD = 6'b111111;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_valid, a_bz, b_valid, b_bz;
    logic [5:0] a_op, b_op;
    logic [4:0] a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;

    logic a_stall, a_flush, a_pcs, a_jump, a_rdst, a_asrc, a_mr, a_mw, a_wbw, a_m2r, a_ill;
    logic b_stall, b_flush, b_pcs, b_jump, b_rdst, b_asrc, b_mr, b_mw, b_wbw, b_m2r, b_ill;
    logic [1:0] a_aop, a_fa, a_fb, b_aop, b_fa, b_fb;
    logic [4:0] a_wa, b_wa;

    ctrl_pipe #(.RA_W(5), .ALU_OP_W(2), .EN_FWD(1'b1)) u_a (
        .clk(clk), .rst(rst), .id_valid(a_valid), .opcode(a_op),
        .id_rs(a_rs), .id_rt(a_rt), .id_rd(a_rd), .br_zero(a_bz),
        .stall(a_stall), .flush_ifid(a_flush), .pc_src(a_pcs), .jump(a_jump),
        .ex_reg_dst(a_rdst), .ex_alu_src(a_asrc), .ex_alu_op(a_aop),
        .mem_read(a_mr), .mem_write(a_mw), .wb_reg_write(a_wbw),
        .wb_mem_to_reg(a_m2r), .wb_wr_addr(a_wa), .fwd_a(a_fa), .fwd_b(a_fb),
        .illegal(a_ill));

    ctrl_pipe #(.RA_W(5), .ALU_OP_W(2), .EN_FWD(1'b0)) u_b (
        .clk(clk), .rst(rst), .id_valid(b_valid), .opcode(b_op),
        .id_rs(b_rs), .id_rt(b_rt), .id_rd(b_rd), .br_zero(b_bz),
        .stall(b_stall), .flush_ifid(b_flush), .pc_src(b_pcs), .jump(b_jump),
        .ex_reg_dst(b_rdst), .ex_alu_src(b_asrc), .ex_alu_op(b_aop),
        .mem_read(b_mr), .mem_write(b_mw), .wb_reg_write(b_wbw),
        .wb_mem_to_reg(b_m2r), .wb_wr_addr(b_wa), .fwd_a(b_fa), .fwd_b(b_fb),
        .illegal(b_ill));

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks run 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ida(input logic [5:0] op, input logic [4:0] rs, rt, rd, input logic bz = 1'b0);
        a_valid = 1'b1; a_op = op; a_rs = rs; a_rt = rt; a_rd = rd; a_bz = bz;
        #2;
    endtask

    task automatic idb(input logic [5:0] op, input logic [4:0] rs, rt, rd, input logic bz = 1'b0);
        b_valid = 1'b1; b_op = op; b_rs = rs; b_rt = rt; b_rd = rd; b_bz = bz;
        #2;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_op = '0; a_rs = '0; a_rt = '0; a_rd = '0; a_bz = 1'b0;
        b_valid = 1'b0; b_op = '0; b_rs = '0; b_rt = '0; b_rd = '0; b_bz = 1'b0;
        #2;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
    endtask

    task automatic chk_all_zero_a(input string tag);
        chk({tag, ".ctl"}, {a_stall, a_flush, a_pcs, a_jump, a_rdst, a_asrc, a_mr, a_mw}, 8'h00);
        chk({tag, ".wb"},  {a_wbw, a_m2r, a_ill, a_wa}, 8'h00);
        chk({tag, ".alu"}, {2'b00, a_aop, a_fa, a_fb}, 8'h00);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_all_zero_a("rst_a");
        chk("rst_b", {b_stall, b_flush, b_pcs, b_jump, b_ill, b_wbw, b_mw, b_mr}, 8'h00);

        // LW r2 ; ADD r3,r2,r4 -> one stall, then MEM/WB forward to A
        ida(LW, 5'd1, 5'd2, 5'd0);
        chk("lw.stall", a_stall, 1'b0);
        tick(); ida(RT, 5'd2, 5'd4, 5'd3);
        chk("lu.stall1", a_stall, 1'b1);
        chk("lu.ex_lw", {a_asrc, a_aop}, 3'b111);
        tick(); ida(RT, 5'd2, 5'd4, 5'd3);
        chk("lu.stall2", a_stall, 1'b0);
        chk("lu.mem_rd", a_mr, 1'b1);
        chk("lu.ex_bub", a_aop, 2'b00);
        tick(); idle();
        chk("lu.fwd_a", a_fa, 2'b01);
        chk("lu.fwd_b", a_fb, 2'b00);
        chk("lu.ex_add", {a_rdst, a_aop}, 3'b110);
        chk("lu.wb", {a_wbw, a_m2r, a_wa}, {2'b11, 5'd2});

        // ADD r5,r1,r1 ; SW r5 -> no stall, EX/MEM forward to B
        do_reset();
        ida(RT, 5'd1, 5'd1, 5'd5);
        tick(); ida(SW, 5'd6, 5'd5, 5'd0);
        chk("sw.stall", a_stall, 1'b0);
        tick(); idle();
        chk("sw.fwd", {a_fa, a_fb}, 4'b0010);
        tick();
        chk("sw.mem_wr", a_mw, 1'b1);
        chk("sw.add_wb", {a_wbw, a_wa}, {1'b1, 5'd5});

        // pc_src beats jump
        do_reset();
        ida(BQ, 5'd1, 5'd2, 5'd0);
        tick(); ida(JJ, 5'd0, 5'd0, 5'd0, 1'b1);
        chk("bj.pcs", {a_pcs, a_flush, a_jump}, 3'b110);

        // J -> jump + flush, nothing written later
        do_reset();
        ida(JJ, 5'd0, 5'd9, 5'd9);
        chk("j.same", {a_jump, a_flush, a_stall, a_pcs}, 4'b1100);
        tick(); idle();
        chk("j.ex_bub", {a_rdst, a_asrc, a_aop}, 4'b0000);
        tick(); tick();
        chk("j.wb", {a_wbw, a_wa}, 6'd0);

        // Illegal opcode is sticky; R-type to r0 never writes
        do_reset();
        ida(BAD, 5'd1, 5'd2, 5'd3);
        chk("ill.pre", a_ill, 1'b0);
        tick(); ida(RT, 5'd1, 5'd2, 5'd0);
        chk("ill.set", a_ill, 1'b1);
        chk("ill.bub", {a_rdst, a_aop}, 3'b000);
        tick(); idle();
        chk("r0.ex", {a_rdst, a_aop}, 3'b110);
        tick(); tick();
        chk("r0.wb", {a_wbw, a_wa}, 6'd0);
        chk("ill.hold", a_ill, 1'b1);
        do_reset();
        chk("ill.clr", a_ill, 1'b0);

        // Illegal opcode squashed by a taken branch does not set illegal
        ida(BQ, 5'd1, 5'd2, 5'd0);
        tick(); ida(BAD, 5'd0, 5'd0, 5'd0, 1'b1);
        chk("sq.pcs", a_pcs, 1'b1);
        tick(); idle();
        chk("sq.ill", a_ill, 1'b0);

        // Reset with all stages full
        do_reset();
        ida(RT, 5'd1, 5'd2, 5'd3);
        tick(); ida(RT, 5'd1, 5'd2, 5'd4);
        tick(); ida(SW, 5'd1, 5'd2, 5'd0);
        tick(); ida(BAD, 5'd0, 5'd0, 5'd0);
        chk("full.wb", {a_wbw, a_wa}, {1'b1, 5'd3});
        tick(); idle();
        chk("full.ill", a_ill, 1'b1);
        rst = 1'b1;
        tick(); rst = 1'b0; #2;
        chk_all_zero_a("rst_mid");

        // No forwarding: ADD r3 ; ADD r5,r3,r4 -> two stall cycles
        idb(RT, 5'd1, 5'd1, 5'd3);
        tick(); idb(RT, 5'd3, 5'd4, 5'd5);
        chk("nf.stall1", b_stall, 1'b1);
        tick(); idb(RT, 5'd3, 5'd4, 5'd5);
        chk("nf.stall2", b_stall, 1'b1);
        tick(); idb(RT, 5'd3, 5'd4, 5'd5);
        chk("nf.stall3", b_stall, 1'b0);
        tick(); idle();
        chk("nf.ex", {b_rdst, b_aop, b_fa, b_fb}, 7'b1100000);

        // Branch in EX beats a RAW stall on the ID instruction
        do_reset();
        idb(RT, 5'd1, 5'd1, 5'd7);
        tick(); idb(BQ, 5'd1, 5'd1, 5'd0);
        chk("bs.pre", b_stall, 1'b0);
        tick(); idb(RT, 5'd7, 5'd1, 5'd8, 1'b1);
        chk("bs.win", {b_pcs, b_flush, b_stall, b_jump}, 4'b1100);
        tick(); idle();
        chk("bs.bub", {b_rdst, b_aop, b_pcs}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 5-stage MIPS core. It decodes the ID-stage opcode and carries the resulting control bits through the ID/EX, EX/MEM and MEM/WB registers. It also owns the core's hazard logic: load-use stall, branch/jump flush, EX-stage operand forwarding select, and illegal-opcode detection. It replaces the purely combinational decoder between the IF/ID register and the datapath muxes.

## Interface
- RA_W, 5: register-address width.
- ALU_OP_W, 2: ALU-op code width; codes are zero-extended to this width.
- EN_FWD, 1: 1 = forwarding enabled; 0 = `fwd_a`/`fwd_b` tied 00 and every RAW hazard stalls.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- opcode  in  6  ID opcode.
- id_rs, id_rt, id_rd  in  RA_W  ID register fields.
- br_zero  in  1  ALU zero flag for the instruction in EX.
- stall  out  1  hold PC and IF/ID (combinational).
- flush_ifid  out  1  squash IF/ID (combinational).
- pc_src  out  1  take branch target (combinational).
- jump  out  1  take jump target (combinational).
- ex_reg_dst, ex_alu_src  out  1 each  EX controls.
- ex_alu_op  out  ALU_OP_W  EX ALU op.
- mem_read, mem_write  out  1 each  MEM controls.
- wb_reg_write, wb_mem_to_reg  out  1 each  WB controls; mem_to_reg=1 selects load data.
- wb_wr_addr  out  RA_W  destination register.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- illegal  out  1  sticky; an unknown opcode was decoded.

## Operation
- Decode table:
  - R-type (000001): reg_dst, reg_write, alu_op 10, uses rs and rt.
  - LW (100011): alu_src, mem_read, reg_write, mem_to_reg, alu_op 11, uses rs.
  - SW (101011): alu_src, mem_write, alu_op 11, uses rs and rt.
  - BEQ (000100): branch, alu_op 01, uses rs and rt.
  - J (001100): jump, no register use.
  - Any other opcode with id_valid: decodes as a bubble and sets `illegal`.
- Destination: rd if reg_dst, else rt. reg_write is forced 0 when the destination is 0.
- Each stage register carries valid, the stage-relevant controls, and the destination address. ID/EX also carries rs and rt.
- Load-use hazard: EX holds a valid LW with nonzero destination matching a used ID source. Result: `stall`=1, IF/ID holds, ID/EX loads a bubble (valid=0, all controls 0).
- EN_FWD=0: a stall is raised on any match against a reg_write destination in EX or MEM.
- Forwarding (EN_FWD=1):
  - `fwd_a`=10 if the EX/MEM stage writes a nonzero destination equal to ex_rs.
  - Else `fwd_a`=01 if the MEM/WB stage does.
  - Else 00.
  - `fwd_b` follows the same rule with ex_rt. The EX/MEM match has priority.
- Branch, resolved in EX: `pc_src` = ex valid & branch & br_zero. This asserts `flush_ifid`, and ID/EX loads a bubble next edge.
- Jump, resolved in ID: `jump` = id_valid & J & !stall & !pc_src. This asserts `flush_ifid`. The J itself enters ID/EX as a bubble.
- Simultaneous events:
  - pc_src beats stall: `stall` is forced 0 because the ID instruction is squashed.
  - pc_src beats jump, since the branch is the older instruction.
  - An illegal opcode that is squashed by pc_src does not set `illegal`.

## Timing
- Stage registers advance on every clock edge; no global enable.
- Latency: ID controls appear on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- stall, flush_ifid, pc_src, jump and fwd_* are same-cycle combinational outputs of the current register state and ID inputs.
- A load-use stall lasts exactly 1 cycle with EN_FWD=1, and up to 2 cycles with EN_FWD=0.
- Reset:
  - All stage valids and controls go to 0, and wb_wr_addr to 0.
  - `illegal` clears to 0.
  - Combinational outputs evaluate to 0 in the first cycle after reset.
  - Reset asserted mid-stall or mid-flush discards all in-flight state at that edge.

## Structure
- Shared package `ctrl_pkg` holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J.
  - ALU-op constants: ALUOP_ADD=11, ALUOP_SUB=01, ALUOP_FUNC=10.
  - FWD_* select codes.
  - Stage control-bundle struct typedefs.
- One sub-module, `ctrl_decode`: purely combinational opcode→bundle decode plus the uses_rs/uses_rt/illegal flags.
- Hazard, forwarding and stage registers live in `ctrl_pipe`.

## Test plan
- LW r2 then ADD r3,r2,r4 (EN_FWD=1) -> exactly 1 stall cycle, then fwd_a=01 when ADD is in EX.
- ADD r5,r1,r1 then SW r5 -> no stall, fwd_b=10 in SW's EX cycle; mem_write=1 two cycles after SW decode.
- BEQ with br_zero=1 in EX while ID holds a load-use-dependent instruction -> pc_src=1, flush_ifid=1, stall=0, next ID/EX is a bubble.
- J with id_valid -> jump=1, flush_ifid=1 same cycle; no write appears at wb 3 cycles later.
- Opcode 111111 -> bubble propagates, illegal=1 and stays 1 until rst. Destination r0 on R-type -> wb_reg_write=0.
- rst asserted with valid instructions in all stages -> every output 0 the next cycle. With EN_FWD=0, an ADD→dependent ADD sequence stalls 2 cycles.
